// File: rtl/vid_sequencer_if.sv
// Display sequencer bus: mode/ISA request in, slot count, VRAM strobes and ISA grant out.
interface vid_sequencer_if #(
    parameter int CNT_W = 5
);
    logic             grph_mode;
    logic [CNT_W-1:0] clk_seq;
    logic             mode_q;
    logic             crtc_clk;
    logic             vram_read;
    logic             vram_read_a0;
    logic             vram_read_char;
    logic             vram_read_att;
    logic [1:0]       fetch_idx;
    logic             charrom_read;
    logic             disp_pipeline;
    logic             isa_req;
    logic             isa_grant;
    logic             isa_busy;

    modport master (
        input  grph_mode, isa_req,
        output clk_seq, mode_q, crtc_clk, vram_read, vram_read_a0, vram_read_char,
               vram_read_att, fetch_idx, charrom_read, disp_pipeline, isa_grant, isa_busy
    );

    modport slave (
        output grph_mode, isa_req,
        input  clk_seq, mode_q, crtc_clk, vram_read, vram_read_a0, vram_read_char,
               vram_read_att, fetch_idx, charrom_read, disp_pipeline, isa_grant, isa_busy
    );
endinterface

// File: rtl/vid_sequencer.sv
// Character-slot sequencer: per-mode period counter, VRAM fetch strobe decode, guarded ISA grant.
// Strobes are a same-cycle decode of the slot count; grant/busy are registered from next-state.
module vid_sequencer #(
    parameter int CNT_W        = 5,
    parameter int TEXT_PERIOD  = 18,
    parameter int GRPH_PERIOD  = 32,
    parameter int GRPH_FETCHES = 2,
    parameter int FETCH_STRIDE = 16,
    parameter int ISA_OP_LEN   = 3,
    parameter int ISA_GUARD    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    vid_sequencer_if.master bus
);
    localparam int BUSY_W = $clog2(ISA_OP_LEN + 1);

    logic [CNT_W-1:0]  clk_seq_q;
    logic              mode_r;
    logic              crtc_r;
    logic              grant_r;
    logic              busy_r;
    logic [BUSY_W-1:0] busy_cnt;

    logic [CNT_W-1:0]  seq_nxt;
    logic              mode_nxt;
    logic              wrap;
    logic [BUSY_W-1:0] busy_left;
    logic [BUSY_W-1:0] busy_nxt;
    logic              grant_nxt;
    int                period;
    int                s_cur;
    int                s_nxt;

    logic       rd, ch, att, crom, disp;
    logic [1:0] fi;

    function automatic logic slot_reads(input int s, input logic m);
        logic r;
        r = 1'b0;
        if (!m) begin
            r = (s >= 1) && (s <= 4);
        end else begin
            for (int k = 0; k < GRPH_FETCHES; k++) begin
                if (s >= 1 + k * FETCH_STRIDE && s <= 3 + k * FETCH_STRIDE) r = 1'b1;
            end
        end
        return r;
    endfunction

    // Distance to the next burst start; past the last burst it is burst 0 of the next period.
    function automatic int slot_dist(input int s, input logic m);
        int d;
        d = (m ? GRPH_PERIOD : TEXT_PERIOD) - s + 1;
        if (!m) begin
            if (s <= 1) d = 1 - s;
        end else begin
            for (int k = GRPH_FETCHES - 1; k >= 0; k--) begin
                if (s <= 1 + k * FETCH_STRIDE) d = 1 + k * FETCH_STRIDE - s;
            end
        end
        return d;
    endfunction

    always_comb begin
        s_cur = int'(clk_seq_q);
        rd    = slot_reads(s_cur, mode_r);
        ch    = 1'b0;
        att   = 1'b0;
        crom  = 1'b0;
        disp  = 1'b0;
        fi    = 2'd0;
        if (!mode_r) begin
            ch   = (s_cur == 3);
            att  = (s_cur == 4);
            crom = (s_cur == 1);
            disp = (s_cur == 4);
        end else begin
            for (int k = 0; k < GRPH_FETCHES; k++) begin
                if (s_cur == 2 + k * FETCH_STRIDE) ch = 1'b1;
                if (s_cur == 3 + k * FETCH_STRIDE) att = 1'b1;
                if (s_cur >= 1 + k * FETCH_STRIDE) fi = 2'(k);
            end
        end
    end

    always_comb begin
        period    = mode_r ? GRPH_PERIOD : TEXT_PERIOD;
        wrap      = (clk_seq_q == CNT_W'(period - 1));
        seq_nxt   = wrap ? '0 : clk_seq_q + CNT_W'(1);
        mode_nxt  = wrap ? bus.grph_mode : mode_r;
        busy_left = (busy_cnt != '0) ? busy_cnt - BUSY_W'(1) : '0;
        s_nxt     = int'(seq_nxt);
        grant_nxt = bus.isa_req && (busy_left == '0) && !slot_reads(s_nxt, mode_nxt)
                    && (slot_dist(s_nxt, mode_nxt) >= ISA_OP_LEN + ISA_GUARD);
        busy_nxt  = grant_nxt ? BUSY_W'(ISA_OP_LEN) : busy_left;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_seq_q <= '0;
            mode_r    <= 1'b0;
            crtc_r    <= 1'b0;
            grant_r   <= 1'b0;
            busy_r    <= 1'b0;
            busy_cnt  <= '0;
        end else begin
            clk_seq_q <= seq_nxt;
            mode_r    <= mode_nxt;
            crtc_r    <= wrap;
            grant_r   <= grant_nxt;
            busy_r    <= (busy_nxt != '0);
            busy_cnt  <= busy_nxt;
        end
    end

    assign bus.clk_seq        = clk_seq_q;
    assign bus.mode_q         = mode_r;
    assign bus.crtc_clk       = crtc_r;
    assign bus.vram_read      = rd;
    assign bus.vram_read_a0   = ch;
    assign bus.vram_read_char = ch;
    assign bus.vram_read_att  = att;
    assign bus.fetch_idx      = fi;
    assign bus.charrom_read   = crom;
    assign bus.disp_pipeline  = disp;
    assign bus.isa_grant      = grant_r;
    assign bus.isa_busy       = busy_r;
endmodule

// File: tb/tb_vid_sequencer.sv
// Scoreboard bench for vid_sequencer: slot-level reference model feeds an expectation queue.
module tb_vid_sequencer;
    localparam int TP = 18, GP = 32, GF = 2, FS = 16, OPL = 3, GRD = 2;

    typedef struct packed {
        logic [4:0] seq;
        logic       mode, crtc, rd, a0, ch, att;
        logic [1:0] fi;
        logic       crom, disp, grant, busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    vid_sequencer_if #(.CNT_W(5)) bus();

    vid_sequencer dut (.clk(clk), .reset_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            if (bad <= 20) $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_start(int s, bit m);
        if (!m) return s == 1;
        return (s >= 1) && ((s - 1) % FS == 0) && ((s - 1) / FS < GF);
    endfunction

    // Walk forward slot by slot until a burst start; period length is that of the current mode.
    function automatic int dist_walk(int s, bit m);
        int p = m ? GP : TP;
        for (int d = 0; d <= p; d++) if (is_start((s + d) % p, m)) return d;
        return p;
    endfunction

    function automatic exp_t slot_out(int s, bit m, bit crtc);
        exp_t e;
        int   bases[$];
        int   rlen;
        e      = '0;
        e.seq  = 5'(s);
        e.mode = m;
        e.crtc = crtc;
        if (m) for (int k = 0; k < GF; k++) bases.push_back(1 + k * FS);
        else bases.push_back(1);
        rlen = m ? 3 : 4;
        foreach (bases[i]) begin
            if (s >= bases[i] && s < bases[i] + rlen) e.rd = 1'b1;
            if (s == bases[i] + (m ? 1 : 2)) begin e.ch = 1'b1; e.a0 = 1'b1; end
            if (s == bases[i] + (m ? 2 : 3)) e.att = 1'b1;
            if (m && s >= bases[i]) e.fi = 2'(i);
        end
        if (!m) begin
            e.crom = (s == 1);
            e.disp = (s == 4);
        end
        return e;
    endfunction

    int m_slot, m_cyc, m_last;
    bit m_mode, m_crtc, m_grant;

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        bit   req_s, gm_s;
        int   p;
        if (!rst_n) begin
            m_slot = 0; m_mode = 0; m_crtc = 0; m_grant = 0; m_cyc = 0; m_last = -100;
            exp_q.delete();
            exp_q.push_back(slot_out(0, 1'b0, 1'b0));
        end else begin
            req_s = bus.isa_req;
            gm_s  = bus.grph_mode;
            p = m_mode ? GP : TP;
            if (m_slot == p - 1) begin
                m_slot = 0; m_mode = gm_s; m_crtc = 1;
            end else begin
                m_slot++; m_crtc = 0;
            end
            m_cyc++;
            e = slot_out(m_slot, m_mode, m_crtc);
            m_grant = req_s && (m_cyc - m_last >= OPL) && !e.rd
                      && (dist_walk(m_slot, m_mode) >= OPL + GRD);
            if (m_grant) m_last = m_cyc;
            e.grant = m_grant;
            e.busy  = (m_cyc - m_last) < OPL;
            exp_q.push_back(e);
        end
    end

    int ncyc = 0;
    int last_crtc = -1;
    bit prev_mode = 0;

    always @(negedge clk) begin
        exp_t e, a;
        bit   ok;
        int   s;
        ncyc++;
        a = {bus.clk_seq, bus.mode_q, bus.crtc_clk, bus.vram_read, bus.vram_read_a0,
             bus.vram_read_char, bus.vram_read_att, bus.fetch_idx, bus.charrom_read,
             bus.disp_pipeline, bus.isa_grant, bus.isa_busy};
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("outputs", 32'(a), 32'(e));
        end
        chk("read_busy_overlap", 32'(bus.vram_read & bus.isa_busy), 32'd0);
        s = int'(bus.clk_seq);
        if (bus.isa_grant) begin
            ok = bus.mode_q ? ((s >= 4 && s <= 12) || (s >= 20 && s <= 28)) : (s >= 5 && s <= 14);
            chk("grant_slot", 32'(ok), 32'd1);
        end
        if (!rst_n) begin
            last_crtc = -1;
        end else if (bus.crtc_clk) begin
            if (last_crtc >= 0) chk("crtc_interval", 32'(ncyc - last_crtc), prev_mode ? 32'd32 : 32'd18);
            last_crtc = ncyc;
        end
        prev_mode = bus.mode_q;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int i;
        rst_n = 1'b1;
        bus.grph_mode = 1'b0;
        bus.isa_req   = 1'b0;
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(40);

        rst_n = 1'b0; bus.grph_mode = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(80);

        rst_n = 1'b0; bus.grph_mode = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(20);
        i = 0;
        while (i < 40 && bus.clk_seq != 5'd9) begin step(1); i++; end
        chk("reach_text_slot9", 32'(bus.clk_seq), 32'd9);
        bus.grph_mode = 1'b1;
        step(60);

        bus.grph_mode = 1'b0; bus.isa_req = 1'b1;
        step(1000);
        bus.grph_mode = 1'b1;
        step(300);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 39) == 0) bus.grph_mode = ~bus.grph_mode;
            bus.isa_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            step(1);
        end

        bus.grph_mode = 1'b1; bus.isa_req = 1'b1;
        i = 0;
        while (i < 200 && !(bus.clk_seq == 5'd10 && bus.mode_q && bus.isa_busy)) begin step(1); i++; end
        chk("busy_at_gfx_slot10", 32'({bus.clk_seq == 5'd10, bus.mode_q, bus.isa_busy}), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("async_clear", 32'({bus.clk_seq, bus.mode_q, bus.crtc_clk, bus.vram_read, bus.vram_read_a0,
                               bus.vram_read_char, bus.vram_read_att, bus.fetch_idx, bus.charrom_read,
                               bus.disp_pipeline, bus.isa_grant, bus.isa_busy}), 32'd0);
        step(2);
        rst_n = 1'b1;
        #1;
        chk("restart_seq_mode", 32'({bus.clk_seq, bus.mode_q}), 32'd0);
        step(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
